receiver_output_reader: RTL and testbench
=========================================

// Module: receiver_output_reader
//
// PURPOSE
// Read-side counterpart of the receiver input stage. The input stage writes
// samples to sample RAM (write_data/write_addr/write_en); this block tracks
// writer progress, issues reads from the same RAM in arrival order and
// streams samples downstream on a valid/ready interface. It detects writer
// lap-around (overflow) and resynchronises to the newest sample.
//
// PARAMETERS
// DATA_W   16   sample width, equals RAM data width
// ADDR_W   16   RAM address width; DEPTH = 1<<ADDR_W entries
//
// PORTS
// clk        in   1       clock, all logic on rising edge
// rst        in   1       asynchronous reset, active high
// enable     in   1       1 = stream samples, 0 = stop issuing reads
// write_addr in   ADDR_W  writer address (monitored, not driven)
// write_en   in   1       writer strobe; one sample committed per cycle high
// read_addr  out  ADDR_W  RAM read address
// read_en    out  1       RAM read strobe; read_data valid next cycle
// read_data  in   DATA_W  RAM read data, 1-cycle synchronous latency
// out_data   out  DATA_W  sample to downstream
// out_valid  out  1       out_data valid
// out_ready  in   1       downstream accepts when out_valid && out_ready
// overflow   out  1       sticky: writer overwrote unread samples
// clear_ovf  in   1       single-cycle pulse, clears overflow
//
// BEHAVIOUR
// - Reset: read_addr=0, read_en=0, out_data=0, out_valid=0, overflow=0;
//   rd_ptr=0, avail=0, skid buffer empty, state=IDLE.
// - avail (ADDR_W+1 bits) = unread samples: +1 on write_en, -1 on read
//   issue, unchanged if both same cycle. Saturates never; see overflow.
// - States: IDLE -> STREAM when enable=1. STREAM -> IDLE when enable=0
//   (in-flight read completes and is buffered; buffered data still
//   drains). Any state -> RESYNC on overflow; RESYNC -> STREAM (enable=1)
//   or IDLE (enable=0) after exactly one cycle.
// - Read issue (STREAM only): avail!=0 and buffered+in-flight < 2. Then
//   read_en=1, read_addr=rd_ptr, rd_ptr<=rd_ptr+1 (wraps mod DEPTH).
// - Output: 2-entry skid buffer captures read_data the cycle after
//   read_en. out_valid high whenever buffer non-empty; out_data = oldest
//   entry, held stable while out_valid && !out_ready. Samples emerge in
//   strict address order, no drops or duplicates outside overflow.
// - Latency: write_en in cycle N into empty block in STREAM -> read_en
//   in N+1 -> out_valid in N+3. Full throughput: 1 sample/cycle with
//   out_ready held high.
// - Overflow: write_en while avail==DEPTH. Then overflow<=1, skid buffer
//   and in-flight read discarded, out_valid<=0, rd_ptr<=write_addr
//   (sampled that cycle), avail<=1, state<=RESYNC. clear_ovf same cycle
//   as new overflow: overflow stays 1.
// - write_en in IDLE still counts into avail (overflow still detected).
// - Reset mid-transfer: all state to reset values immediately; pending
//   samples lost.
//
// TESTING
// 1 Reset, enable=1, write_en 1 cycle (write_addr=0, data 0x1234) ->
//   read_en 1 cycle later with read_addr=0; out_valid 3 cycles after,
//   out_data=0x1234.
// 2 Write 100 consecutive samples (data=addr), out_ready=1 -> outputs
//   0..99 in order, one per cycle, avail ends 0, overflow=0.
// 3 Random out_ready (50%) during 1000-sample stream -> no loss or
//   duplicate; out_data stable while stalled.
// 4 ADDR_W=4, enable=0, 17 writes -> overflow=1 on 17th; enable=1 ->
//   next output equals sample at 17th write_addr; clear_ovf -> overflow=0.
// 5 write_en and read issue same cycle for 50 cycles -> avail constant.
// 6 Assert rst mid-stream with 2 samples buffered -> outputs to reset
//   values same cycle, no out_valid until new writes arrive.

Source files
------------

// File: rtl/receiver_output_reader.sv
// Read side of the receiver sample RAM: follows writer progress, issues RAM
// reads in arrival order, and streams samples out through a two-entry skid
// buffer. A writer lap-around is flagged as a sticky overflow, and the reader
// then restarts at the newest sample.
module receiver_output_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              write_en,
    output logic [ADDR_W-1:0] read_addr,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    input  logic              clear_ovf
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     avail_q, avail_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   buf0_q, buf0_d;
    logic [DATA_W-1:0]   buf1_q, buf1_d;
    logic                ovf_q, ovf_d;

    logic                ovf_evt;
    logic                pop;
    logic                push;
    logic                issue;
    logic [1:0]          occ;

    // Issue decision and overflow detection. The occupancy test counts the
    // entry leaving this cycle, so back-to-back reads sustain one sample
    // per cycle while the skid buffer never exceeds two entries.
    always_comb begin
        ovf_evt = write_en && (avail_q == DEPTH);
        pop     = (cnt_q != 2'd0) && out_ready;
        push    = inflight_q;
        occ     = cnt_q - {1'b0, pop} + {1'b0, inflight_q};
        issue   = (state_q == STREAM) && (avail_q != '0) && (occ < 2'd2);
    end

    // Next-state for the FSM, read pointer, unread count and overflow flag.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        avail_d    = avail_q;
        inflight_d = issue;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE:    state_d = enable ? STREAM : IDLE;
            STREAM:  state_d = enable ? STREAM : IDLE;
            RESYNC:  state_d = enable ? STREAM : IDLE;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({write_en, issue})
            2'b10:   avail_d = avail_q + 1'b1;
            2'b01:   avail_d = avail_q - 1'b1;
            default: avail_d = avail_q;
        endcase

        if (clear_ovf) begin
            ovf_d = 1'b0;
        end

        // Writer lapped the reader: jump to the sample being written now
        // and drop everything already fetched.
        if (ovf_evt) begin
            state_d    = RESYNC;
            rd_ptr_d   = write_addr;
            avail_d    = {{ADDR_W{1'b0}}, 1'b1};
            inflight_d = 1'b0;
            ovf_d      = 1'b1;
        end
    end

    // Skid buffer next-state: entry 0 is always the oldest sample.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        if (ovf_evt) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        buf0_d = read_data;
                    end else begin
                        buf1_d = read_data;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    buf0_d = buf1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        buf0_d = read_data;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = read_data;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            avail_q    <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            avail_q    <= avail_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Skid buffer storage; cleared on reset so out_data starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
        end
    end

    // Output mapping.
    always_comb begin
        read_en   = issue;
        read_addr = rd_ptr_q;
        out_data  = buf0_q;
        out_valid = (cnt_q != 2'd0);
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_receiver_output_reader.sv
// Bench for receiver_output_reader with a small RAM model and a queue-based
// reference model of the sample stream.
module tb_receiver_output_reader;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [AW-1:0] write_addr;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_addr;
    logic          read_en;
    logic [DW-1:0] read_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic          clear_ovf;

    logic [DW-1:0] mem [0:DEPTH-1];

    int            n_cmp = 0;
    int            n_fail = 0;
    int            cyc = 0;

    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] wa = '0;

    bit            track = 1'b0;
    int            acc_cnt = 0;
    int            first_acc = -1;
    int            last_acc = -1;

    receiver_output_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .write_addr (write_addr),
        .write_en   (write_en),
        .read_addr  (read_addr),
        .read_en    (read_en),
        .read_data  (read_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample RAM: write port from the bench writer, 1-cycle read port.
    always @(posedge clk) begin
        if (write_en) mem[write_addr] <= write_data;
        if (read_en) read_data <= mem[read_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model and per-cycle comparison, evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            prev_stall = 1'b0;
            chk("rst_out_valid", {31'd0, out_valid}, 0);
            chk("rst_read_en", {31'd0, read_en}, 0);
            chk("rst_overflow", {31'd0, overflow}, 0);
            chk("rst_out_data", {16'd0, out_data}, 0);
            chk("rst_read_addr", {28'd0, read_addr}, 0);
        end else begin
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_valid", {31'd0, out_valid}, 0);
                else chk("out_data", {16'd0, out_data}, {16'd0, q[0]});
            end
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 1);
                chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                if (track) begin
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    acc_cnt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (write_en && q.size() >= DEPTH) begin
                q.delete();
                q.push_back(write_data);
                m_ovf = 1'b1;
                prev_stall = 1'b0;
            end else begin
                if (write_en) q.push_back(write_data);
                if (clear_ovf) m_ovf = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit we, input logic [DW-1:0] d, input bit cl);
        write_en   = we;
        write_addr = wa;
        write_data = d;
        clear_ovf  = cl;
        if (we) wa = wa + 1'b1;
    endtask

    task automatic step(input bit we, input logic [DW-1:0] d, input bit cl);
        tick();
        put(we, d, cl);
    endtask

    task automatic drain();
        int n;
        enable = 1'b1;
        out_ready = 1'b1;
        n = 0;
        step(0, '0, 0);
        while ((q.size() != 0 || out_valid) && n < 300) begin
            step(0, '0, 0);
            n++;
        end
        chk("drain_left", q.size(), 0);
        repeat (3) step(0, '0, 0);
    endtask

    task automatic fill_overflow(input bit cl_on_ovf, input logic [DW-1:0] last_d);
        drain();
        enable = 1'b0;
        repeat (2) step(0, '0, 0);
        for (int i = 0; i < DEPTH; i++) step(1, DW'(16'hA000 + i), 0);
        #1;
        chk("ovf_before_lap", {31'd0, overflow}, 0);
        step(1, last_d, cl_on_ovf);
        step(0, '0, 0);
        #1;
        chk("ovf_on_lap", {31'd0, overflow}, 1);
    endtask

    initial begin
        int n;
        int first_wr;
        bit we;
        rst = 1'b1;
        enable = 1'b0;
        write_en = 1'b0;
        write_addr = '0;
        write_data = '0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write: read issued next cycle, output three cycles after.
        enable = 1'b1;
        out_ready = 1'b1;
        repeat (3) step(0, '0, 0);
        step(1, 16'h1234, 0);
        step(0, '0, 0);
        #1;
        chk("t1_read_en", {31'd0, read_en}, 1);
        chk("t1_read_addr", {28'd0, read_addr}, 0);
        step(0, '0, 0);
        #1;
        chk("t1_read_en_off", {31'd0, read_en}, 0);
        chk("t1_not_yet_valid", {31'd0, out_valid}, 0);
        step(0, '0, 0);
        #1;
        chk("t1_out_valid", {31'd0, out_valid}, 1);
        chk("t1_out_data", {16'd0, out_data}, 32'h1234);
        drain();

        // 100 back-to-back samples at full throughput; reads issue every cycle.
        acc_cnt = 0;
        first_acc = -1;
        last_acc = -1;
        track = 1'b1;
        first_wr = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, DW'(i), 0);
            if (i == 0) first_wr = cyc;
            if (i >= 1 && i <= 50) begin
                #1;
                chk("t5_read_steady", {31'd0, read_en}, 1);
            end
        end
        drain();
        track = 1'b0;
        chk("t2_count", acc_cnt, 100);
        chk("t2_latency", first_acc - first_wr, 3);
        chk("t2_throughput", last_acc - first_acc, 99);
        chk("t2_overflow", {31'd0, overflow}, 0);

        // Randomized stall/enable traffic, writer kept behind the reader.
        n = 0;
        while (n < 1000) begin
            tick();
            we = (q.size() < DEPTH - 1) && ($urandom_range(0, 99) < 60);
            put(we, DW'($urandom), 0);
            if (we) n++;
            out_ready = ($urandom_range(0, 1) == 1);
            enable = ($urandom_range(0, 19) != 0);
        end
        drain();
        chk("t3_overflow", {31'd0, overflow}, 0);

        // Writer laps the reader while idle: resync to the newest sample.
        fill_overflow(1'b0, 16'hBEEF);
        enable = 1'b1;
        out_ready = 1'b1;
        n = 0;
        step(0, '0, 0);
        while (!out_valid && n < 20) begin
            step(0, '0, 0);
            n++;
        end
        chk("t4_resync_valid", {31'd0, out_valid}, 1);
        chk("t4_resync_data", {16'd0, out_data}, 32'hBEEF);
        step(0, '0, 1);
        step(0, '0, 0);
        #1;
        chk("t4_cleared", {31'd0, overflow}, 0);

        // Clear arriving in the same cycle as a new lap leaves the flag set.
        fill_overflow(1'b1, 16'hC0DE);
        step(0, '0, 1);
        step(0, '0, 0);
        #1;
        chk("t4b_cleared", {31'd0, overflow}, 0);
        drain();

        // Asynchronous reset with two samples held in the skid buffer.
        enable = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1, DW'(16'h5500 + i), 0);
        repeat (6) step(0, '0, 0);
        #1;
        chk("t6_buffered", {31'd0, out_valid}, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 0);
        chk("t6_rst_data", {16'd0, out_data}, 0);
        chk("t6_rst_read_en", {31'd0, read_en}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wa = '0;
        out_ready = 1'b1;
        repeat (10) step(0, '0, 0);
        #1;
        chk("t6_quiet_after_rst", {31'd0, out_valid}, 0);
        for (int i = 0; i < 5; i++) step(1, DW'(16'h7700 + i), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
